tdp_port_arb: RTL
=================

TDP_PORT_ARB -- requirements
Module: tdp_port_arb

Interface
REQ-001 Parameter DW, default 16, data width in bits.
REQ-002 Parameter AW, default 15, address width in bits.
REQ-003 Parameter DEPTH, default 20480, number of valid memory words.
REQ-004 Port list, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0 / req1  in  1  access request, requester 0 / 1.
- lock0 / lock1  in  1  keep ownership across consecutive requests.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  AW  word address.
- wdata0 / wdata1  in  DW  write data.
- gnt0 / gnt1  out  1  access accepted this cycle (combinational).
- rdata0 / rdata1  out  DW  registered read data.
- rvalid0 / rvalid1  out  1  rdata valid, one-cycle pulse.
- mem_wen  out  1  to memory port write enable.
- mem_addr  out  AW  to memory port address.
- mem_din  out  DW  to memory port write data.
- mem_dout  in  DW  from memory port; combinational read of mem_addr.
- err  out  1  sticky out-of-range flag (see REQ-020).

Function
REQ-005 The block shall share one memory port between two requesters, with at most one access per cycle.
REQ-006 A request shall be accepted (gntN=1) in the cycle reqN=1 and the requester wins arbitration; the requester holds we/addr/wdata stable while reqN=1 and gntN=0.
REQ-007 The arbiter state machine shall have states IDLE, OWN0 and OWN1, plus a 1-bit round-robin pointer prio, which selects the favoured requester.
REQ-008 IDLE: if only one request is present, it wins; if both are present, requester prio wins.
REQ-009 Every grant without lock shall set prio to the other requester and leave the state at IDLE.
REQ-010 A grant to requester N with lockN=1 shall move the state to OWNN.
REQ-011 OWNN: requester N has absolute priority, and the other request waits.
- Return to IDLE when reqN=0 or lockN=0 in a cycle.
- prio then points to the other requester.
- A grant in the unlocking cycle is still issued if reqN=1.
REQ-012 Without lock, a waiting request shall be granted within 2 cycles.
REQ-013 mem_addr, mem_din and mem_wen shall be combinational from the granted requester.
- With no grant: mem_wen=0, mem_addr=0, mem_din=0.
REQ-014 mem_wen=1 only for a granted write.
REQ-015 A granted read shall register mem_dout into rdataN on that clock edge.
- rvalidN=1 for exactly the following cycle; latency 1.
- rdataN holds its value until the next read for N.
REQ-016 A granted write shall produce no rvalid.
REQ-017 Back-to-back reads by one requester shall give a continuous rvalid stream at one word per cycle.
REQ-018 A read and a write to the same address in consecutive cycles shall see memory order (read-after-write returns the new data).

Reset
REQ-019 While rst=1 at a clock edge, the block shall reset to:
- state=IDLE, prio=0, rvalid0=rvalid1=0, rdata0=rdata1=0, err=0.
- gnt0=gnt1=0 and mem_wen=0 during reset regardless of req.
- An in-flight read's rvalid is discarded.

Configuration
REQ-020 With macro TDP_ARB_BOUNDS_CHECK_EN defined:
- A request with addrN >= DEPTH is still granted (consumes its slot).
- mem_wen is forced to 0 for that access.
- A read returns rdataN=0 with rvalidN=1.
- err is set and stays set until rst.
Without the macro: no address check; addresses pass through unchanged; err is tied to 0.

Verification
REQ-021 After reset, req0=req1=1, no lock, reads to addr 10/20 for 4 cycles -> grants alternate 0,1,0,1; each rvalid follows one cycle after its grant.
REQ-022 req0 write addr 5 data 0xA5A5, next cycle req1 read addr 5 -> rdata1=0xA5A5, rvalid1=1 in the third cycle.
REQ-023 lock0=1 with req0 held 6 cycles while req1=1 -> gnt0 for 6 cycles, gnt1=0. lock0 drops -> gnt1 within 1 cycle.
REQ-024 rst asserted the cycle after a granted read -> no rvalid; state IDLE; prio=0 (both requesting -> requester 0 wins first).
REQ-025 With TDP_ARB_BOUNDS_CHECK_EN, write addr 20480 then read addr 20480 -> mem_wen=0, rdata=0 with rvalid=1, err=1 until reset. Without the macro -> access passes through, err=0.

Source files
------------

// File: rtl/tdp_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : tdp_port_arb
// Purpose  : Two-requester round-robin arbiter with lock, sharing one memory
//            port. Optional bounds check under macro TDP_ARB_BOUNDS_CHECK_EN.
// Revision : 1.0
// ============================================================================
module tdp_port_arb #(
    parameter int DW    = 16,
    parameter int AW    = 15,
    parameter int DEPTH = 20480
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          err
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_OWN0 = 2'd1;
    localparam logic [1:0] c_S_OWN1 = 2'd2;

`ifdef TDP_ARB_BOUNDS_CHECK_EN
    localparam bit c_BOUNDS_EN = 1'b1;
`else
    localparam bit c_BOUNDS_EN = 1'b0;
`endif

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_prio;
    logic          w_prio_nxt;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any;
    logic          w_we_sel;
    logic [AW-1:0] w_addr_sel;
    logic [DW-1:0] w_wdata_sel;
    logic          w_oob;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic          r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    // Locked owner leaves on the first cycle it drops req or lock.
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        case (r_state)
            c_S_OWN0: begin
                if (!req0 || !lock0) begin
                    w_state_nxt = c_S_IDLE;
                    w_prio_nxt  = 1'b1;
                end
            end
            c_S_OWN1: begin
                if (!req1 || !lock1) begin
                    w_state_nxt = c_S_IDLE;
                    w_prio_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                if (w_gnt0) begin
                    if (lock0) w_state_nxt = c_S_OWN0;
                    else       w_prio_nxt  = 1'b1;
                end else if (w_gnt1) begin
                    if (lock1) w_state_nxt = c_S_OWN1;
                    else       w_prio_nxt  = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            case (r_state)
                c_S_OWN0: w_gnt0 = req0;
                c_S_OWN1: w_gnt1 = req1;
                default: begin
                    if (req0 && req1) begin
                        w_gnt0 = ~r_prio;
                        w_gnt1 = r_prio;
                    end else begin
                        w_gnt0 = req0;
                        w_gnt1 = req1;
                    end
                end
            endcase
        end
    end

    assign w_any       = w_gnt0 | w_gnt1;
    assign w_we_sel    = w_gnt1 ? we1    : we0;
    assign w_addr_sel  = w_gnt1 ? addr1  : addr0;
    assign w_wdata_sel = w_gnt1 ? wdata1 : wdata0;
    assign w_oob       = c_BOUNDS_EN && ({1'b0, w_addr_sel} >= c_DEPTH);

    assign mem_wen  = w_any & w_we_sel & ~w_oob;
    assign mem_addr = w_any ? w_addr_sel  : '0;
    assign mem_din  = w_any ? w_wdata_sel : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~we0;
            r_rvalid1 <= w_gnt1 & ~we1;
            if (w_gnt0 && !we0) r_rdata0 <= w_oob ? '0 : mem_dout;
            if (w_gnt1 && !we1) r_rdata1 <= w_oob ? '0 : mem_dout;
            if (w_any && w_oob) r_err <= 1'b1;
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign err     = r_err;

endmodule
`default_nettype wire
